// File: rtl/demux2_buf.sv
// Registered 1-to-2 stream demultiplexer with a 2-entry FIFO per output.
// Each word on the input goes to out0 or out1 according to in_sel.
module demux2_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [1:0]       occ0,
  output logic [1:0]       occ1
);

  logic [WIDTH-1:0] mem_q  [2][2];
  logic [WIDTH-1:0] mem_d  [2][2];
  logic [WIDTH-1:0] head_q [2];
  logic [WIDTH-1:0] head_d [2];
  logic [1:0]       occ_q  [2];
  logic [1:0]       occ_d  [2];
  logic [1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       sel_vec, out_ready, push, pop;

  assign sel_vec   = {in_sel, ~in_sel};
  assign out_ready = {out1_ready, out0_ready};
  // A full FIFO never accepts, so in_ready does not depend on out*_ready.
  assign in_ready  = !flush && (in_sel ? (occ_q[1] != 2'd2) : (occ_q[0] != 2'd2));

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    occ_d  = occ_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    push   = '0;
    pop    = '0;
    for (int i = 0; i < 2; i++) begin
      push[i] = in_valid && in_ready && sel_vec[i];
      pop[i]  = !flush && (occ_q[i] != 2'd0) && out_ready[i];
      if (flush) begin
        occ_d[i] = 2'd0;
        wr_d[i]  = 1'b0;
        rd_d[i]  = 1'b0;
      end else begin
        if (push[i]) begin
          mem_d[i][wr_q[i]] = in_data;
          wr_d[i]           = ~wr_q[i];
        end
        if (pop[i]) begin
          rd_d[i] = ~rd_q[i];
        end
        if (push[i] && !pop[i]) begin
          occ_d[i] = occ_q[i] + 2'd1;
        end else if (pop[i] && !push[i]) begin
          occ_d[i] = occ_q[i] - 2'd1;
        end
        // The head register mirrors mem[rd] so outN_data comes straight from a flop.
        if (push[i] && (occ_q[i] == 2'd0 || pop[i])) begin
          head_d[i] = in_data;
        end else if (pop[i] && occ_q[i] == 2'd2) begin
          head_d[i] = mem_q[i][~rd_q[i]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i][0] <= '0;
        mem_q[i][1] <= '0;
        head_q[i]   <= '0;
        occ_q[i]    <= 2'd0;
      end
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      occ_q  <= occ_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
    end
  end

  assign occ0       = occ_q[0];
  assign occ1       = occ_q[1];
  assign out0_valid = (occ_q[0] != 2'd0);
  assign out1_valid = (occ_q[1] != 2'd0);
  assign out0_data  = head_q[0];
  assign out1_data  = head_q[1];

endmodule

// File: tb/tb_demux2_buf.sv
// Table-driven bench for demux2_buf, plus hand-written async reset sequence.
module tb_demux2_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic [31:0] out0_data, out1_data;
  logic [1:0]  occ0, occ1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux2_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .occ0      (occ0),
    .occ1      (occ1)
  );

  typedef struct {
    logic        fl, v, sel;
    logic [31:0] d;
    logic        r0, r1;
    logic        ir;    // expected in_ready before the edge
    logic [1:0]  o0, o1; // expected occupancies after the edge
    logic [31:0] d0, d1; // expected heads after the edge (checked when non-empty)
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic v, logic sel, logic [31:0] d, logic r0, logic r1,
                              logic ir, logic [1:0] o0, logic [1:0] o1,
                              logic [31:0] d0, logic [31:0] d1);
    vec_t t;
    t.fl = fl; t.v = v; t.sel = sel; t.d = d; t.r0 = r0; t.r1 = r1;
    t.ir = ir; t.o0 = o0; t.o1 = o1; t.d0 = d0; t.d1 = d1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    flush = t.fl; in_valid = t.v; in_sel = t.sel; in_data = t.d;
    out0_ready = t.r0; out1_ready = t.r1;
    #1;
    chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(t.ir));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d occ0", idx), 32'(occ0), 32'(t.o0));
    chk($sformatf("v%0d occ1", idx), 32'(occ1), 32'(t.o1));
    chk($sformatf("v%0d out0_valid", idx), 32'(out0_valid), 32'(t.o0 != 2'd0));
    chk($sformatf("v%0d out1_valid", idx), 32'(out1_valid), 32'(t.o1 != 2'd0));
    if (t.o0 != 2'd0) chk($sformatf("v%0d out0_data", idx), out0_data, t.d0);
    if (t.o1 != 2'd0) chk($sformatf("v%0d out1_data", idx), out1_data, t.d1);
  endtask

  task automatic check_empty(input string tag);
    chk({tag, " occ0"}, 32'(occ0), 32'd0);
    chk({tag, " occ1"}, 32'(occ1), 32'd0);
    chk({tag, " out0_valid"}, 32'(out0_valid), 32'd0);
    chk({tag, " out1_valid"}, 32'(out1_valid), 32'd0);
    chk({tag, " out0_data"}, out0_data, 32'd0);
    chk({tag, " out1_data"}, out1_data, 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    // Single route
    vecs.push_back(mk(0,1,0,32'h419c03fc, 0,0, 1, 1,0, 32'h419c03fc, 0));
    vecs.push_back(mk(0,1,1,32'h6b58400b, 0,0, 1, 1,1, 32'h419c03fc, 32'h6b58400b));
    vecs.push_back(mk(0,0,0,0,            0,0, 1, 1,1, 32'h419c03fc, 32'h6b58400b));
    vecs.push_back(mk(0,0,0,0,            0,1, 1, 1,0, 32'h419c03fc, 0));
    vecs.push_back(mk(0,0,0,0,            1,0, 1, 0,0, 0, 0));
    // Fill and backpressure
    vecs.push_back(mk(0,1,0,32'h74d7edc6, 0,0, 1, 1,0, 32'h74d7edc6, 0));
    vecs.push_back(mk(0,1,0,32'hb6f0d434, 0,0, 1, 2,0, 32'h74d7edc6, 0));
    vecs.push_back(mk(0,1,0,32'hdc2242bd, 0,0, 0, 2,0, 32'h74d7edc6, 0));
    vecs.push_back(mk(0,1,1,32'h0a0a0a0a, 0,0, 1, 2,1, 32'h74d7edc6, 32'h0a0a0a0a));
    vecs.push_back(mk(0,1,0,32'hdc2242bd, 1,1, 0, 1,0, 32'hb6f0d434, 0));
    vecs.push_back(mk(0,1,0,32'hdc2242bd, 1,0, 1, 1,0, 32'hdc2242bd, 0));
    vecs.push_back(mk(0,0,0,0,            1,0, 1, 0,0, 0, 0));
    // Streaming: 8 words, occ0 stays at 1
    for (int i = 0; i < 8; i++) begin
      w = 32'h10000000 + 32'(i) * 32'h01010101;
      vecs.push_back(mk(0,1,0,w, 1,0, 1, 1,0, w, 0));
    end
    vecs.push_back(mk(0,0,0,0,            1,0, 1, 0,0, 0, 0));
    // Simultaneous push/pop at occ=1
    vecs.push_back(mk(0,1,0,32'hba5fb2db, 0,0, 1, 1,0, 32'hba5fb2db, 0));
    vecs.push_back(mk(0,1,0,32'h11111111, 1,0, 1, 1,0, 32'h11111111, 0));
    vecs.push_back(mk(0,0,0,0,            1,0, 1, 0,0, 0, 0));
    // Flush with occ0=2, occ1=1, then pointers must restart at 0
    vecs.push_back(mk(0,1,0,32'ha1a1a1a1, 0,0, 1, 1,0, 32'ha1a1a1a1, 0));
    vecs.push_back(mk(0,1,0,32'ha2a2a2a2, 0,0, 1, 2,0, 32'ha1a1a1a1, 0));
    vecs.push_back(mk(0,1,1,32'hb1b1b1b1, 0,0, 1, 2,1, 32'ha1a1a1a1, 32'hb1b1b1b1));
    vecs.push_back(mk(1,1,1,32'hdeadbeef, 1,1, 0, 0,0, 0, 0));
    vecs.push_back(mk(0,1,1,32'hc1c1c1c1, 0,0, 1, 0,1, 0, 32'hc1c1c1c1));
    vecs.push_back(mk(0,1,1,32'hc3c3c3c3, 0,0, 1, 0,2, 0, 32'hc1c1c1c1));
    vecs.push_back(mk(0,1,0,32'hc2c2c2c2, 0,1, 1, 1,1, 32'hc2c2c2c2, 32'hc3c3c3c3));
    vecs.push_back(mk(0,0,0,0,            1,1, 1, 0,0, 0, 0));

    // Reset state
    #1;
    check_empty("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Async reset mid-operation with occ0=2
    apply(mk(0,1,0,32'h33333333, 0,0, 1, 1,0, 32'h33333333, 0), 100);
    apply(mk(0,1,0,32'h44444444, 0,0, 1, 2,0, 32'h33333333, 0), 101);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_empty("async_rst");
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0,1,0,32'h5a5a5a5a, 0,0, 1, 1,0, 32'h5a5a5a5a, 0), 102);
    apply(mk(0,0,0,0,            1,0, 1, 0,0, 0, 0), 103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux2_buf.md
# demux2_buf

Registered 1-to-2 stream demultiplexer: routes each 32-bit word accepted on a single valid/ready input to one of two output streams, as selected by a per-word select bit. Each output has its own 2-entry FIFO, so a stalled consumer does not block traffic bound for the other output until its own FIFO fills. It is the fan-out counterpart of mux2 in the pipeline: one producer (for example a result or response path) feeds two consumers. A synchronous flush supports pipeline squash.

## Interface
- WIDTH, 32, data width of every stream
- DEPTH, 2, entries per output FIFO; fixed at 2, no other value is supported
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of both FIFOs
- in_valid  in  1  input word present
- in_ready  out  1  input word can be accepted
- in_data  in  WIDTH  input word
- in_sel  in  1  destination: 0 means out0, 1 means out1; must be held stable with in_data while in_valid=1
- out0_valid / out1_valid  out  1  the output FIFO is non-empty
- out0_ready / out1_ready  in  1  the consumer takes the head word
- out0_data / out1_data  out  WIDTH  head word of each FIFO
- occ0 / occ1  out  2  occupancy of each FIFO, range 0..2

## Operation
- Push: in_valid & in_ready at a rising edge writes in_data into the FIFO selected by in_sel.
- in_ready = !flush & (in_sel ? occ1!=2 : occ0!=2).
  - in_ready has no combinational path from out*_ready; a full FIFO never accepts, even in a cycle where it is popped.
- Pop: outN_valid & outN_ready at a rising edge removes the head entry of FIFO N.
- outN_valid = (occN != 0).
- outN_data = head entry of FIFO N; it is driven from a register, with no logic after the storage.
- Per FIFO, the storage is a 2-entry circular buffer with 1-bit read and write pointers that wrap 1→0.
- Occupancy update for each FIFO:
  - push only: occ+1
  - pop only: occ-1
  - push and pop together, only possible at occ=1: occ stays 1, the head advances, and the new word becomes the head
  - neither: unchanged
- Ordering is FIFO within each output. There is no ordering guarantee between out0 and out1.
- Flush has priority over push and pop in the same cycle. It sets both occupancies and all pointers to 0, and no word is accepted or delivered in that cycle. Stored data values need not be cleared.
- Reset (asynchronous, any time, including mid-transfer):
  - occ0 = occ1 = 0, all pointers = 0, storage = 0
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0
  - in_ready follows its equation, so it is 1 when flush=0

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on outN_valid/outN_data immediately after edge k and can be popped at edge k+1.
- Throughput is 1 word per cycle into each output when its consumer holds ready=1. A steady stream to one output runs at occ=1 with no bubbles.
- With a consumer stalled, at most 2 words are accepted for it. in_ready drops (for that in_sel) in the cycle after the second push. The other output keeps flowing.
- Simultaneous pushes to both outputs in one cycle are impossible, because there is a single input.
- Deassertion of rst is assumed synchronous to clk (handled outside this block).

## Test plan
- Single route:
  - out1_ready=0; push 32'h419c03fc with sel=0, then 32'h6b58400b with sel=1.
  - Required: out0_data=419c03fc (occ0=1) after edge 1; out1_data=6b58400b (occ1=1) after edge 2. out1 holds that value until out1_ready=1, then occ1=0.
- Fill and backpressure:
  - out0_ready=0; push 74d7edc6, b6f0d434, dc2242bd, all with sel=0.
  - Required: first two accepted; occ0=2; in_ready=0 for the third.
  - Required: with sel=1 offered instead, in_ready=1 and the word is accepted into out1.
  - Then raise out0_ready: 74d7edc6 and b6f0d434 drain in order; the third word is accepted once occ0<2.
- Streaming:
  - out0_ready=1; push 8 consecutive words with sel=0.
  - Required: in_ready stays 1 throughout; each word is seen on out0 one cycle after acceptance; occ0 stays ≤1.
- Simultaneous push/pop at occ=1:
  - occ0=1 holding ba5fb2db; push 11111111 with sel=0 and pop in the same cycle.
  - Required: occ0=1 and out0_data=11111111.
- Flush:
  - Set occ0=2, occ1=1; assert flush together with in_valid and both ready signals.
  - Required: in_ready=0 in that cycle; after the edge occ0=occ1=0 and both valids=0; nothing was popped or pushed.
- Async reset mid-operation:
  - With occ0=2, assert rst between clock edges.
  - Required: occ0=occ1=0, both valids=0 and both data outputs=0 immediately, without waiting for a clock edge. The first push after release is delivered correctly.
